// File: rtl/p_hardisc.sv
// Shared definitions for the physical-memory-attribute checker.
//   pma_cfg_t      : reset-time description of one region (base, mask, attributes)
//   PMA_DEFAULT    : region that matches every address, executable, writable
//   ATTR_*_BIT     : bit positions inside the attribute configuration word
//   SEL_*          : configuration field selects
//   pma_cause_t    : cause code reported for a captured violation
package p_hardisc;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
    logic        executable;
    logic        read_only;
    logic        idempotent;
  } pma_cfg_t;

  localparam pma_cfg_t PMA_DEFAULT = '{
    base:       32'h0000_0000,
    mask:       32'h0000_0000,
    executable: 1'b1,
    read_only:  1'b0,
    idempotent: 1'b0
  };

  localparam int ATTR_EXEC_BIT = 0;
  localparam int ATTR_RO_BIT   = 1;
  localparam int ATTR_IDEM_BIT = 2;
  localparam int ATTR_EN_BIT   = 3;
  localparam int ATTR_LOCK_BIT = 31;

  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_MASK = 2'd1;
  localparam logic [1:0] SEL_ATTR = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  typedef enum logic [1:0] {
    CAUSE_NO_HIT   = 2'd0,
    CAUSE_NOT_EXEC = 2'd1,
    CAUSE_RO_WRITE = 2'd2
  } pma_cause_t;

  // Assemble the architecturally visible attribute word; unused bits read 0.
  function automatic logic [31:0] pack_attr(input logic lock, input logic en,
                                            input logic idem, input logic ro,
                                            input logic exec);
    logic [31:0] w;
    w                = '0;
    w[ATTR_LOCK_BIT] = lock;
    w[ATTR_EN_BIT]   = en;
    w[ATTR_IDEM_BIT] = idem;
    w[ATTR_RO_BIT]   = ro;
    w[ATTR_EXEC_BIT] = exec;
    return w;
  endfunction

endpackage

// File: rtl/pma_region.sv
// One PMA region: base/mask/attribute registers, lock handling and address match.
// Ports:
//   i_clk, i_resetn : clock, synchronous active-low reset
//   i_we            : configuration write strobe already decoded for this region
//   i_sel, i_wdata  : field select and write data
//   i_addr          : lookup address
//   o_base, o_mask  : current base and mask
//   o_attr          : current attribute word (readback format)
//   o_hit           : region enabled and address matches
//   o_exec, o_ro, o_idem : region attributes
module pma_region
  import p_hardisc::*;
#(
  parameter pma_cfg_t RST_CFG = PMA_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_we,
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_addr,
  output logic [31:0] o_base,
  output logic [31:0] o_mask,
  output logic [31:0] o_attr,
  output logic        o_hit,
  output logic        o_exec,
  output logic        o_ro,
  output logic        o_idem
);

  logic [31:0] r_base;
  logic [31:0] r_mask;
  logic        r_exec;
  logic        r_ro;
  logic        r_idem;
  logic        r_en;
  logic        r_lock;

  // A locked region ignores every field write, the lock bit included; only
  // reset can reopen it.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_base <= RST_CFG.base;
      r_mask <= RST_CFG.mask;
      r_exec <= RST_CFG.executable;
      r_ro   <= RST_CFG.read_only;
      r_idem <= RST_CFG.idempotent;
      r_en   <= 1'b1;
      r_lock <= 1'b0;
    end else if (i_we && !r_lock) begin
      case (i_sel)
        SEL_BASE: r_base <= i_wdata;
        SEL_MASK: r_mask <= i_wdata;
        SEL_ATTR: begin
          r_exec <= i_wdata[ATTR_EXEC_BIT];
          r_ro   <= i_wdata[ATTR_RO_BIT];
          r_idem <= i_wdata[ATTR_IDEM_BIT];
          r_en   <= i_wdata[ATTR_EN_BIT];
          r_lock <= i_wdata[ATTR_LOCK_BIT];
        end
        default: begin
        end
      endcase
    end
  end

  assign o_base = r_base;
  assign o_mask = r_mask;
  assign o_attr = pack_attr(r_lock, r_en, r_idem, r_ro, r_exec);
  assign o_hit  = r_en && ((i_addr & r_mask) == r_base);
  assign o_exec = r_exec;
  assign o_ro   = r_ro;
  assign o_idem = r_idem;

endmodule

// File: rtl/pma_unit.sv
// Physical-memory-attribute checker with PMA_REGIONS first-match regions.
// A lookup sampled at one edge produces a registered response at the next.
// Ports:
//   s_clk_i, s_resetn_i            : clock, synchronous active-low reset
//   s_req_i, s_address_i, s_write_i: lookup request
//   s_rsp_valid_o, s_idempotent_o, s_violation_o : registered lookup response
//   s_cfg_we_i, s_cfg_idx_i, s_cfg_sel_i, s_cfg_wdata_i : configuration write
//   s_cfg_rdata_o                  : registered readback of idx/sel
//   s_viol_valid_o, s_viol_addr_o, s_viol_cause_o : first captured violation
//   s_viol_clear_i                 : clears capture and counter
//   s_viol_count_o                 : saturating violation count
module pma_unit
  import p_hardisc::*;
#(
  parameter bit                             FETCH       = 1'b0,
  parameter int                             PMA_REGIONS = 4,
  parameter pma_cfg_t [PMA_REGIONS-1:0]     PMA_CFG     = {PMA_REGIONS{PMA_DEFAULT}},
  parameter int                             IDX_W       = (PMA_REGIONS > 1) ? $clog2(PMA_REGIONS) : 1
) (
  input  logic             s_clk_i,
  input  logic             s_resetn_i,
  input  logic             s_req_i,
  input  logic [31:0]      s_address_i,
  input  logic             s_write_i,
  output logic             s_rsp_valid_o,
  output logic             s_idempotent_o,
  output logic             s_violation_o,
  input  logic             s_cfg_we_i,
  input  logic [IDX_W-1:0] s_cfg_idx_i,
  input  logic [1:0]       s_cfg_sel_i,
  input  logic [31:0]      s_cfg_wdata_i,
  output logic [31:0]      s_cfg_rdata_o,
  output logic             s_viol_valid_o,
  output logic [31:0]      s_viol_addr_o,
  output logic [1:0]       s_viol_cause_o,
  input  logic             s_viol_clear_i,
  output logic [7:0]       s_viol_count_o
);

  logic [31:0] w_base [PMA_REGIONS];
  logic [31:0] w_mask [PMA_REGIONS];
  logic [31:0] w_attr [PMA_REGIONS];
  logic        w_hit  [PMA_REGIONS];
  logic        w_exec [PMA_REGIONS];
  logic        w_ro   [PMA_REGIONS];
  logic        w_idem [PMA_REGIONS];
  logic        w_we   [PMA_REGIONS];

  logic        w_any_hit;
  logic        w_m_exec;
  logic        w_m_ro;
  logic        w_m_idem;
  logic        w_viol;
  pma_cause_t  w_cause;
  logic        w_req_viol;
  logic [31:0] w_rdata;

  logic        r_rsp_valid_p1;
  logic        r_idem_p1;
  logic        r_viol_p1;
  logic [31:0] r_rdata_p1;
  logic        r_viol_valid;
  logic [31:0] r_viol_addr;
  pma_cause_t  r_viol_cause;
  logic [7:0]  r_viol_count;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  for (genvar g = 0; g < PMA_REGIONS; g++) begin : g_region
    // An out-of-range index matches no region, so its write is dropped here.
    assign w_we[g] = s_cfg_we_i && (s_cfg_idx_i == IDX_W'(g));

    pma_region #(
      .RST_CFG (PMA_CFG[g])
    ) u_region (
      .i_clk    (s_clk_i),
      .i_resetn (s_resetn_i),
      .i_we     (w_we[g]),
      .i_sel    (s_cfg_sel_i),
      .i_wdata  (s_cfg_wdata_i),
      .i_addr   (s_address_i),
      .o_base   (w_base[g]),
      .o_mask   (w_mask[g]),
      .o_attr   (w_attr[g]),
      .o_hit    (w_hit[g]),
      .o_exec   (w_exec[g]),
      .o_ro     (w_ro[g]),
      .o_idem   (w_idem[g])
    );
  end

  // Scan from the top index down so the lowest-index hit is the last writer
  // and therefore the one whose attributes survive.
  always_comb begin
    w_any_hit = 1'b0;
    w_m_exec  = 1'b0;
    w_m_ro    = 1'b0;
    w_m_idem  = 1'b0;
    for (int i = PMA_REGIONS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any_hit = 1'b1;
        w_m_exec  = w_exec[i];
        w_m_ro    = w_ro[i];
        w_m_idem  = w_idem[i];
      end
    end
  end

  always_comb begin
    w_viol  = 1'b0;
    w_cause = CAUSE_NO_HIT;
    if (!w_any_hit) begin
      w_viol  = 1'b1;
      w_cause = CAUSE_NO_HIT;
    end else if (FETCH && !w_m_exec) begin
      w_viol  = 1'b1;
      w_cause = CAUSE_NOT_EXEC;
    end else if (!FETCH && s_write_i && w_m_ro) begin
      w_viol  = 1'b1;
      w_cause = CAUSE_RO_WRITE;
    end
  end

  assign w_req_viol = s_req_i && w_viol;

  // Readback uses the register contents before any same-cycle write lands.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < PMA_REGIONS; i++) begin
      if (s_cfg_idx_i == IDX_W'(i)) begin
        case (s_cfg_sel_i)
          SEL_BASE: w_rdata = w_base[i];
          SEL_MASK: w_rdata = w_mask[i];
          SEL_ATTR: w_rdata = w_attr[i];
          default:  w_rdata = '0;
        endcase
      end
    end
  end

  // ---- stage p0 -> p1: lookup response and readback ----
  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      r_rsp_valid_p1 <= 1'b0;
      r_idem_p1      <= 1'b0;
      r_viol_p1      <= 1'b0;
      r_rdata_p1     <= '0;
    end else begin
      r_rsp_valid_p1 <= s_req_i;
      r_idem_p1      <= s_req_i && w_any_hit && w_m_idem;
      r_viol_p1      <= w_req_viol;
      r_rdata_p1     <= w_rdata;
    end
  end

  // Capture and count alongside the response; clear acts before a
  // same-cycle violation so that violation becomes the new first capture.
  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      r_viol_valid <= 1'b0;
      r_viol_addr  <= '0;
      r_viol_cause <= CAUSE_NO_HIT;
      r_viol_count <= '0;
    end else if (s_viol_clear_i) begin
      r_viol_valid <= w_req_viol;
      r_viol_addr  <= w_req_viol ? s_address_i : 32'h0;
      r_viol_cause <= w_req_viol ? w_cause : CAUSE_NO_HIT;
      r_viol_count <= {7'd0, w_req_viol};
    end else if (w_req_viol) begin
      if (!r_viol_valid) begin
        r_viol_valid <= 1'b1;
        r_viol_addr  <= s_address_i;
        r_viol_cause <= w_cause;
      end
      r_viol_count <= sat_inc(r_viol_count);
    end
  end

  assign s_rsp_valid_o  = r_rsp_valid_p1;
  assign s_idempotent_o = r_idem_p1;
  assign s_violation_o  = r_viol_p1;
  assign s_cfg_rdata_o  = r_rdata_p1;
  assign s_viol_valid_o = r_viol_valid;
  assign s_viol_addr_o  = r_viol_addr;
  assign s_viol_cause_o = r_viol_cause;
  assign s_viol_count_o = r_viol_count;

endmodule

// File: tb/tb_pma_unit.sv
// Bench for pma_unit: one fetch-mode instance with default regions and one
// data-mode instance with custom reset regions, sharing every input.
module tb_pma_unit;
  import p_hardisc::*;

  localparam pma_cfg_t [3:0] TB_CFG_D = {
    pma_cfg_t'{base: 32'h8000_0000, mask: 32'hC000_0000, executable: 1'b0, read_only: 1'b0, idempotent: 1'b1},
    pma_cfg_t'{base: 32'h2000_0000, mask: 32'hF000_0000, executable: 1'b1, read_only: 1'b1, idempotent: 1'b1},
    pma_cfg_t'{base: 32'h1000_0000, mask: 32'hF000_0000, executable: 1'b0, read_only: 1'b1, idempotent: 1'b0},
    pma_cfg_t'{base: 32'h0000_0000, mask: 32'hF000_0000, executable: 1'b1, read_only: 1'b0, idempotent: 1'b1}
  };

  logic        clk;
  logic        resetn;
  logic        req;
  logic [31:0] addr;
  logic        wr;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic        clr;

  logic        rv_f, idem_f, viol_f, vv_f, rv_d, idem_d, viol_d, vv_d;
  logic [31:0] rdata_f, va_f, rdata_d, va_d;
  logic [1:0]  vc_f, vc_d;
  logic [7:0]  cnt_f, cnt_d;

  int checks   = 0;
  int failures = 0;

  pma_unit #(.FETCH(1'b1), .PMA_REGIONS(4)) u_dut_f (
    .s_clk_i(clk), .s_resetn_i(resetn), .s_req_i(req), .s_address_i(addr), .s_write_i(wr),
    .s_rsp_valid_o(rv_f), .s_idempotent_o(idem_f), .s_violation_o(viol_f),
    .s_cfg_we_i(cfg_we), .s_cfg_idx_i(cfg_idx), .s_cfg_sel_i(cfg_sel), .s_cfg_wdata_i(cfg_wdata),
    .s_cfg_rdata_o(rdata_f), .s_viol_valid_o(vv_f), .s_viol_addr_o(va_f), .s_viol_cause_o(vc_f),
    .s_viol_clear_i(clr), .s_viol_count_o(cnt_f)
  );

  pma_unit #(.FETCH(1'b0), .PMA_REGIONS(4), .PMA_CFG(TB_CFG_D)) u_dut_d (
    .s_clk_i(clk), .s_resetn_i(resetn), .s_req_i(req), .s_address_i(addr), .s_write_i(wr),
    .s_rsp_valid_o(rv_d), .s_idempotent_o(idem_d), .s_violation_o(viol_d),
    .s_cfg_we_i(cfg_we), .s_cfg_idx_i(cfg_idx), .s_cfg_sel_i(cfg_sel), .s_cfg_wdata_i(cfg_wdata),
    .s_cfg_rdata_o(rdata_d), .s_viol_valid_o(vv_d), .s_viol_addr_o(va_d), .s_viol_cause_o(vc_d),
    .s_viol_clear_i(clr), .s_viol_count_o(cnt_d)
  );

  // Index 0 = fetch instance, 1 = data instance.
  logic        a_rv[2], a_idem[2], a_viol[2], a_vv[2];
  logic [31:0] a_rdata[2], a_va[2];
  logic [1:0]  a_vc[2];
  logic [7:0]  a_cnt[2];
  assign a_rv[0] = rv_f;       assign a_rv[1] = rv_d;
  assign a_idem[0] = idem_f;   assign a_idem[1] = idem_d;
  assign a_viol[0] = viol_f;   assign a_viol[1] = viol_d;
  assign a_vv[0] = vv_f;       assign a_vv[1] = vv_d;
  assign a_rdata[0] = rdata_f; assign a_rdata[1] = rdata_d;
  assign a_va[0] = va_f;       assign a_va[1] = va_d;
  assign a_vc[0] = vc_f;       assign a_vc[1] = vc_d;
  assign a_cnt[0] = cnt_f;     assign a_cnt[1] = cnt_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [31:0] m_base[2][4], m_mask[2][4];
  bit        m_exec[2][4], m_ro[2][4], m_idem[2][4], m_en[2][4], m_lock[2][4];
  bit        e_rv[2], e_idem[2], e_viol[2];
  bit [31:0] e_rdata[2];
  bit        m_vv[2];
  bit [31:0] m_va[2];
  bit [1:0]  m_vc[2];
  int        m_cnt[2];

  function automatic bit [31:0] m_attr(int d, int i);
    return (32'(m_lock[d][i]) << 31) | (32'(m_en[d][i]) << 3) | (32'(m_idem[d][i]) << 2)
         | (32'(m_ro[d][i]) << 1) | 32'(m_exec[d][i]);
  endfunction

  task automatic model_reset(int d);
    for (int i = 0; i < 4; i++) begin
      if (d == 0) begin
        m_base[d][i] = 0; m_mask[d][i] = 0; m_exec[d][i] = 1; m_ro[d][i] = 0; m_idem[d][i] = 0;
      end else begin
        m_base[d][i] = TB_CFG_D[i].base;       m_mask[d][i] = TB_CFG_D[i].mask;
        m_exec[d][i] = TB_CFG_D[i].executable; m_ro[d][i]   = TB_CFG_D[i].read_only;
        m_idem[d][i] = TB_CFG_D[i].idempotent;
      end
      m_en[d][i] = 1; m_lock[d][i] = 0;
    end
    e_rv[d] = 0; e_idem[d] = 0; e_viol[d] = 0; e_rdata[d] = 0;
    m_vv[d] = 0; m_va[d] = 0; m_vc[d] = 0; m_cnt[d] = 0;
  endtask

  // Predict the state after the coming edge from the inputs now applied.
  task automatic model_step();
    int hit;
    bit v;
    bit [1:0] c;
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        model_reset(d);
      end else begin
        hit = -1;
        for (int i = 0; i < 4; i++)
          if (hit < 0 && m_en[d][i] && ((addr & m_mask[d][i]) == m_base[d][i])) hit = i;
        if (hit < 0) begin v = 1; c = 0; end
        else if (d == 0) begin v = !m_exec[d][hit]; c = 1; end
        else begin v = wr && m_ro[d][hit]; c = 2; end
        e_rv[d]   = req;
        e_idem[d] = req && (hit >= 0) && m_idem[d][(hit < 0) ? 0 : hit];
        e_viol[d] = req && v;
        case (cfg_sel)
          2'd0: e_rdata[d] = m_base[d][cfg_idx];
          2'd1: e_rdata[d] = m_mask[d][cfg_idx];
          2'd2: e_rdata[d] = m_attr(d, int'(cfg_idx));
          default: e_rdata[d] = 0;
        endcase
        if (clr) begin
          m_vv[d] = req && v; m_va[d] = (req && v) ? addr : 0;
          m_vc[d] = (req && v) ? c : 0; m_cnt[d] = (req && v) ? 1 : 0;
        end else if (req && v) begin
          if (!m_vv[d]) begin m_vv[d] = 1; m_va[d] = addr; m_vc[d] = c; end
          if (m_cnt[d] < 255) m_cnt[d]++;
        end
        if (cfg_we && cfg_sel != 2'd3 && !m_lock[d][cfg_idx]) begin
          case (cfg_sel)
            2'd0: m_base[d][cfg_idx] = cfg_wdata;
            2'd1: m_mask[d][cfg_idx] = cfg_wdata;
            default: begin
              m_exec[d][cfg_idx] = cfg_wdata[0]; m_ro[d][cfg_idx] = cfg_wdata[1];
              m_idem[d][cfg_idx] = cfg_wdata[2]; m_en[d][cfg_idx] = cfg_wdata[3];
              m_lock[d][cfg_idx] = cfg_wdata[31];
            end
          endcase
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [1:0] sel, input logic [31:0] data);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] idx, input logic [1:0] sel);
    cfg_we = 1'b0; cfg_idx = idx; cfg_sel = sel;
    tick();
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000 | ($urandom & 32'h0000_FFFF);
      1: return 32'h1000_0000 | ($urandom & 32'h0FFF_FFFF);
      2: return 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
      3: return 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
      4: return 32'hC000_0000 | ($urandom & 32'h0FFF_FFFF);
      5: return 32'hFFFF_FFF0;
      6: return 32'h5000_0000 | ($urandom & 32'h0000_FFFF);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; req = 1'b1; addr = 32'h1234_5678; wr = 1'b1;
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_sel = 2'd0; cfg_wdata = 32'hFFFF_FFFF; clr = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      checks++; if (a_rv[d] !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid[%0d]: got %b expected 0", d, a_rv[d]); end
      checks++; if (a_idem[d] !== 1'b0 || a_viol[d] !== 1'b0) begin failures++; $display("FAIL reset_idem_viol[%0d]: got %b%b expected 00", d, a_idem[d], a_viol[d]); end
      checks++; if (a_rdata[d] !== 32'h0) begin failures++; $display("FAIL reset_rdata[%0d]: got %h expected 0", d, a_rdata[d]); end
      checks++; if (a_vv[d] !== 1'b0 || a_va[d] !== 32'h0 || a_vc[d] !== 2'd0 || a_cnt[d] !== 8'd0) begin
        failures++; $display("FAIL reset_capture[%0d]: got v=%b a=%h c=%0d n=%0d expected all 0", d, a_vv[d], a_va[d], a_vc[d], a_cnt[d]); end
    end
    resetn = 1'b1; req = 1'b0; wr = 1'b0; cfg_we = 1'b0;
    cfg_read(2'd1, 2'd2);
    checks++; if (rdata_f !== 32'h0000_0009) begin failures++; $display("FAIL reset_attr_f: got %h expected 00000009", rdata_f); end
    checks++; if (rdata_d !== 32'h0000_000A) begin failures++; $display("FAIL reset_attr_d: got %h expected 0000000a", rdata_d); end
    cfg_read(2'd1, 2'd0);
    checks++; if (rdata_d !== 32'h1000_0000) begin failures++; $display("FAIL reset_base_d: got %h expected 10000000", rdata_d); end
    cfg_read(2'd3, 2'd1);
    checks++; if (rdata_d !== 32'hC000_0000) begin failures++; $display("FAIL reset_mask_d: got %h expected c0000000", rdata_d); end
  endtask

  task automatic test_fetch_hit();
    cfg_write(2'd0, 2'd0, 32'h0000_0000);
    cfg_write(2'd0, 2'd1, 32'hFFFF_0000);
    cfg_write(2'd0, 2'd2, 32'h0000_0009);
    req = 1'b1; addr = 32'h0000_1234; wr = 1'b0;
    tick();
    req = 1'b0;
    checks++; if (rv_f !== 1'b1) begin failures++; $display("FAIL fetch_hit_valid: got %b expected 1", rv_f); end
    checks++; if (viol_f !== 1'b0) begin failures++; $display("FAIL fetch_hit_viol: got %b expected 0", viol_f); end
    checks++; if (idem_f !== 1'b0) begin failures++; $display("FAIL fetch_hit_idem: got %b expected 0", idem_f); end
    tick();
    checks++; if (rv_f !== 1'b0) begin failures++; $display("FAIL fetch_valid_drop: got %b expected 0", rv_f); end
    checks++; if (cnt_f !== 8'd0) begin failures++; $display("FAIL fetch_hit_count: got %0d expected 0", cnt_f); end
  endtask

  task automatic test_first_match();
    cfg_write(2'd0, 2'd0, 32'h8000_0000);
    cfg_write(2'd0, 2'd1, 32'hF000_0000);
    cfg_write(2'd0, 2'd2, 32'h0000_0008);
    cfg_write(2'd1, 2'd0, 32'h8000_0000);
    cfg_write(2'd1, 2'd1, 32'hF000_0000);
    cfg_write(2'd1, 2'd2, 32'h0000_0009);
    clr = 1'b1; tick(); clr = 1'b0;
    req = 1'b1; addr = 32'h8000_0010; wr = 1'b0;
    tick();
    req = 1'b0;
    checks++; if (rv_f !== 1'b1 || viol_f !== 1'b1) begin failures++; $display("FAIL first_match_viol: got v=%b x=%b expected 1 1", rv_f, viol_f); end
    checks++; if (vv_f !== 1'b1 || va_f !== 32'h8000_0010) begin failures++; $display("FAIL first_match_addr: got %b %h expected 1 80000010", vv_f, va_f); end
    checks++; if (vc_f !== 2'd1 || cnt_f !== 8'd1) begin failures++; $display("FAIL first_match_cause: got c=%0d n=%0d expected 1 1", vc_f, cnt_f); end
    checks++; if (rv_d !== 1'b1 || viol_d !== 1'b0) begin failures++; $display("FAIL data_read_ok: got v=%b x=%b expected 1 0", rv_d, viol_d); end
  endtask

  task automatic test_readonly();
    cfg_write(2'd0, 2'd0, 32'h1000_0000);
    cfg_write(2'd0, 2'd1, 32'hF000_0000);
    cfg_write(2'd0, 2'd2, 32'h0000_000A);
    clr = 1'b1; tick(); clr = 1'b0;
    req = 1'b1; wr = 1'b1; addr = 32'h1000_0000;
    tick();
    checks++; if (viol_d !== 1'b1) begin failures++; $display("FAIL ro_write1: got %b expected 1", viol_d); end
    addr = 32'h1000_0004;
    tick();
    wr = 1'b0; addr = 32'h1000_0008;
    tick();
    checks++; if (viol_d !== 1'b0) begin failures++; $display("FAIL ro_read: got %b expected 0", viol_d); end
    req = 1'b0;
    tick();
    checks++; if (vv_d !== 1'b1 || va_d !== 32'h1000_0000) begin failures++; $display("FAIL ro_capture: got %b %h expected 1 10000000", vv_d, va_d); end
    checks++; if (vc_d !== 2'd2 || cnt_d !== 8'd2) begin failures++; $display("FAIL ro_cause_count: got c=%0d n=%0d expected 2 2", vc_d, cnt_d); end
    cfg_write(2'd0, 2'd2, 32'h0000_000E);
    req = 1'b1; addr = 32'h1000_0010;
    tick();
    req = 1'b0;
    checks++; if (idem_d !== 1'b1) begin failures++; $display("FAIL idem_flag: got %b expected 1", idem_d); end
  endtask

  task automatic test_lock();
    cfg_write(2'd2, 2'd0, 32'h3000_0000);
    cfg_write(2'd2, 2'd2, 32'h8000_0009);
    cfg_write(2'd2, 2'd0, 32'hDEAD_0000);
    cfg_write(2'd2, 2'd2, 32'h0000_0000);
    cfg_read(2'd2, 2'd0);
    checks++; if (rdata_d !== 32'h3000_0000 || rdata_f !== 32'h3000_0000) begin failures++; $display("FAIL lock_base: got %h %h expected 30000000", rdata_f, rdata_d); end
    cfg_read(2'd2, 2'd2);
    checks++; if (rdata_d !== 32'h8000_0009) begin failures++; $display("FAIL lock_attr: got %h expected 80000009", rdata_d); end
    resetn = 1'b0; tick(); resetn = 1'b1;
    cfg_read(2'd2, 2'd2);
    checks++; if (rdata_d !== 32'h0000_000F || rdata_f !== 32'h0000_0009) begin failures++; $display("FAIL lock_reset_attr: got %h %h expected 00000009 0000000f", rdata_f, rdata_d); end
    cfg_write(2'd2, 2'd0, 32'h4000_0000);
    cfg_read(2'd2, 2'd0);
    checks++; if (rdata_d !== 32'h4000_0000) begin failures++; $display("FAIL unlock_write: got %h expected 40000000", rdata_d); end
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_sel = 2'd0; cfg_wdata = 32'h5000_0000;
    tick();
    cfg_we = 1'b0;
    checks++; if (rdata_d !== 32'h4000_0000) begin failures++; $display("FAIL same_cycle_read_old: got %h expected 40000000", rdata_d); end
    cfg_read(2'd2, 2'd0);
    checks++; if (rdata_d !== 32'h5000_0000) begin failures++; $display("FAIL write_visible: got %h expected 50000000", rdata_d); end
    cfg_write(2'd1, 2'd3, 32'hFFFF_FFFF);
    cfg_read(2'd1, 2'd3);
    checks++; if (rdata_d !== 32'h0 || rdata_f !== 32'h0) begin failures++; $display("FAIL sel3_read: got %h %h expected 0", rdata_f, rdata_d); end
    cfg_write(2'd3, 2'd2, 32'h7FFF_FFF7);
    cfg_read(2'd3, 2'd2);
    checks++; if (rdata_d !== 32'h0000_0007) begin failures++; $display("FAIL attr_reserved: got %h expected 00000007", rdata_d); end
  endtask

  task automatic test_clear_same_cycle();
    req = 1'b1; wr = 1'b1; addr = 32'h1000_0000;
    tick();
    wr = 1'b0; clr = 1'b1; addr = 32'hFFFF_FFF0;
    tick();
    clr = 1'b0; req = 1'b0;
    checks++; if (vv_d !== 1'b1 || va_d !== 32'hFFFF_FFF0) begin failures++; $display("FAIL clear_capture: got %b %h expected 1 fffffff0", vv_d, va_d); end
    checks++; if (vc_d !== 2'd0 || cnt_d !== 8'd1) begin failures++; $display("FAIL clear_count: got c=%0d n=%0d expected 0 1", vc_d, cnt_d); end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (vv_d !== 1'b0 || va_d !== 32'h0 || cnt_d !== 8'd0) begin failures++; $display("FAIL clear_only: got %b %h %0d expected 0 0 0", vv_d, va_d, cnt_d); end
  endtask

  task automatic test_back_to_back_saturate();
    req = 1'b1; wr = 1'b0; addr = 32'hFFFF_FFF0;
    repeat (254) tick();
    checks++; if (cnt_d !== 8'd254) begin failures++; $display("FAIL count_254: got %0d expected 254", cnt_d); end
    repeat (46) tick();
    checks++; if (cnt_d !== 8'd255) begin failures++; $display("FAIL count_sat: got %0d expected 255", cnt_d); end
    checks++; if (vv_d !== 1'b1 || va_d !== 32'hFFFF_FFF0 || rv_d !== 1'b1) begin failures++; $display("FAIL b2b_state: got %b %h %b expected 1 fffffff0 1", vv_d, va_d, rv_d); end
    resetn = 1'b0;
    tick();
    checks++; if (rv_d !== 1'b0 || rv_f !== 1'b0) begin failures++; $display("FAIL inflight_drop: got %b %b expected 0 0", rv_f, rv_d); end
    checks++; if (cnt_d !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", cnt_d); end
    resetn = 1'b1; req = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      resetn = ($urandom_range(0, 99) != 0);
      req    = $urandom_range(0, 3) != 0;
      addr   = pick_addr();
      wr     = $urandom_range(0, 1);
      clr    = $urandom_range(0, 15) == 0;
      cfg_we = $urandom_range(0, 3) == 0;
      cfg_idx = 2'($urandom_range(0, 3));
      cfg_sel = 2'($urandom_range(0, 3));
      case (cfg_sel)
        2'd0: cfg_wdata = pick_addr() & (($urandom_range(0, 1) != 0) ? 32'hF000_0000 : 32'hFFFF_0000);
        2'd1: case ($urandom_range(0, 4))
                0: cfg_wdata = 32'hF000_0000;
                1: cfg_wdata = 32'hFFFF_0000;
                2: cfg_wdata = 32'hC000_0000;
                3: cfg_wdata = 32'h0000_0000;
                default: cfg_wdata = 32'hFFFF_FFFF;
              endcase
        default: cfg_wdata = ($urandom & 32'h7FFF_FFFF) | (($urandom_range(0, 15) == 0) ? 32'h8000_0000 : 32'h0);
      endcase
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++; if (a_rv[d] !== e_rv[d]) begin failures++; $display("FAIL rnd_rsp_valid[%0d] n=%0d: got %b expected %b", d, n, a_rv[d], e_rv[d]); end
        checks++; if (a_idem[d] !== e_idem[d]) begin failures++; $display("FAIL rnd_idem[%0d] n=%0d: got %b expected %b", d, n, a_idem[d], e_idem[d]); end
        checks++; if (a_viol[d] !== e_viol[d]) begin failures++; $display("FAIL rnd_viol[%0d] n=%0d: got %b expected %b", d, n, a_viol[d], e_viol[d]); end
        checks++; if (a_rdata[d] !== e_rdata[d]) begin failures++; $display("FAIL rnd_rdata[%0d] n=%0d: got %h expected %h", d, n, a_rdata[d], e_rdata[d]); end
        checks++; if (a_vv[d] !== m_vv[d]) begin failures++; $display("FAIL rnd_viol_valid[%0d] n=%0d: got %b expected %b", d, n, a_vv[d], m_vv[d]); end
        checks++; if (a_va[d] !== m_va[d]) begin failures++; $display("FAIL rnd_viol_addr[%0d] n=%0d: got %h expected %h", d, n, a_va[d], m_va[d]); end
        checks++; if (a_vc[d] !== m_vc[d]) begin failures++; $display("FAIL rnd_viol_cause[%0d] n=%0d: got %0d expected %0d", d, n, a_vc[d], m_vc[d]); end
        checks++; if (a_cnt[d] !== 8'(m_cnt[d])) begin failures++; $display("FAIL rnd_count[%0d] n=%0d: got %0d expected %0d", d, n, a_cnt[d], m_cnt[d]); end
      end
    end
    resetn = 1'b1; req = 1'b0; cfg_we = 1'b0; clr = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; addr = '0; wr = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_wdata = '0; clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_fetch_hit();
    test_first_match();
    test_readonly();
    test_lock();
    test_clear_same_cycle();
    test_back_to_back_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pma_unit.md
PMA_UNIT -- requirements
Module: pma_unit

Interface
REQ-001 Parameter FETCH, default 0: 1 = instruction-fetch checker (executable check); 0 = data checker (read-only check).
REQ-002 Parameter PMA_REGIONS, default 4, legal range 1..16: number of regions.
REQ-003 Parameter PMA_CFG[PMA_REGIONS-1:0], default '{default:PMA_DEFAULT}: reset-time region configuration of type pma_cfg_t.
REQ-004 Parameter IDX_W, default max(1,$clog2(PMA_REGIONS)): region index width.
REQ-005 s_clk_i  in  1  clock; one clock; all state on rising edge.
REQ-006 s_resetn_i  in  1  reset; synchronous, active-low.
REQ-007 s_req_i  in  1  lookup request valid.
REQ-008 s_address_i  in  32  lookup address.
REQ-009 s_write_i  in  1  lookup is a write.
REQ-010 s_rsp_valid_o  out  1  response valid, one cycle after s_req_i.
REQ-011 s_idempotent_o  out  1  matched region is idempotent; qualified by s_rsp_valid_o.
REQ-012 s_violation_o  out  1  attribute violation; qualified by s_rsp_valid_o.
REQ-013 s_cfg_we_i  in  1  configuration write strobe.
REQ-014 s_cfg_idx_i  in  IDX_W  configuration region index.
REQ-015 s_cfg_sel_i  in  2  field select: 0 base, 1 mask, 2 attributes, 3 reserved.
REQ-016 s_cfg_wdata_i  in  32  write data.
REQ-017 s_cfg_rdata_o  out  32  registered read data for idx/sel from the previous cycle.
REQ-018 s_viol_valid_o  out  1  sticky captured violation present.
REQ-019 s_viol_addr_o  out  32  address of the first captured violation.
REQ-020 s_viol_cause_o  out  2  cause: 0 no-hit, 1 not-executable, 2 read-only write.
REQ-021 s_viol_clear_i  in  1  clears capture registers.
REQ-022 s_viol_count_o  out  8  saturating violation counter.

Function
REQ-023 Hit of region i: attribute enable bit set and (s_address_i & mask_i) == base_i.
REQ-024 Priority: the lowest-index hit region alone supplies attributes (first match); higher-index hits are ignored.
REQ-025 Violation: no hit; or FETCH=1 and matched region not executable; or FETCH=0, s_write_i=1 and matched region read-only.
REQ-026 Latency: the response for the request sampled at edge N is registered and presented at N+1; s_rsp_valid_o equals s_req_i of the previous cycle; back-to-back requests at one per cycle; no backpressure.
REQ-027 When s_rsp_valid_o=0, s_idempotent_o and s_violation_o read 0.
REQ-028 Attribute word bits: [0] executable, [1] read_only, [2] idempotent, [3] enable, [31] lock; other bits write-ignored, read 0.
REQ-029 A configuration write takes effect from the next edge; a lookup in the same cycle uses the old configuration.
REQ-030 A write to a region whose lock bit is set is ignored for all fields, including the lock bit.
REQ-031 Writes with index >= PMA_REGIONS or sel=3 are ignored; reads of them return 0.
REQ-032 Capture: on a violating response with s_viol_valid_o=0, load address and cause and set s_viol_valid_o; later violations do not overwrite.
REQ-033 Counter increments by 1 per violating response and saturates at 255.
REQ-034 s_viol_clear_i zeros valid, address, cause and counter; a violation in the same cycle is then captured and counted as 1 (clear first, then capture).

Reset
REQ-035 While s_resetn_i=0 at an edge: base/mask from PMA_CFG, executable/read_only/idempotent from PMA_CFG, enable=1, lock=0.
REQ-036 Reset values of all outputs are 0: s_rsp_valid_o, s_idempotent_o, s_violation_o, s_cfg_rdata_o, s_viol_valid_o, s_viol_addr_o, s_viol_cause_o, s_viol_count_o.
REQ-037 Reset asserted mid-operation drops the in-flight response; no response is presented in the cycle after reset releases.

Structure
REQ-038 p_hardisc holds pma_cfg_t, PMA_DEFAULT, attribute bit-position constants and the cause enumeration pma_cause_t.
REQ-039 Sub-module pma_region holds one region's registers, lock logic and hit/attribute outputs; it is instantiated PMA_REGIONS times.

Verification
REQ-040 Region0 base 0x0000_0000 mask 0xFFFF_0000 exec; FETCH=1; request 0x0000_1234 -> next cycle valid=1, violation=0.
REQ-041 Region0 base 0x8000_0000 mask 0xF000_0000 non-exec; region1 base 0x8000_0000 mask 0xF000_0000 exec; FETCH=1; request 0x8000_0010 -> violation=1, cause=1 (first match).
REQ-042 FETCH=0; region read-only; write to 0x1000_0000, then write to 0x1000_0004 -> viol_addr=0x1000_0000, cause=2, count=2.
REQ-043 Lock region2 (attr 0x8000_0009); write base 0xDEAD_0000 -> base readback unchanged; reset -> lock=0.
REQ-044 Clear and violating request to 0xFFFF_FFF0 (no hit) in the same cycle -> viol_valid=1, addr=0xFFFF_FFF0, cause=0, count=1.
REQ-045 300 consecutive violating requests -> count=255; reset asserted with a request in flight -> rsp_valid=0 next cycle.
